rr_arbiter_4: RTL

- 4-requester round-robin arbiter with a bounded grant-hold time.
- Shares one downstream resource among four requesters.
- The winner is held as a 2-bit index and expanded to a one-hot grant vector by a 2-to-4 decoder stage.
- Sits between request sources and a shared bus/resource port.

---
 rtl/rr_arbiter_4_pkg.sv | 12 +
 rtl/rr_grant_decode.sv | 23 ++
 rtl/rr_arbiter_4.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding and the
// default grant-hold limit.
package rr_arbiter_4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/rr_grant_decode.sv
// Expands the 2-bit winner index into a one-hot grant; en_i low forces all-zero.
module rr_grant_decode (
  input  logic [1:0] idx_i,
  input  logic       en_i,
  output logic [3:0] gnt_o
);

  always_comb begin
    gnt_o = 4'b0000;
    if (en_i) begin
      case (idx_i)
        2'd0:    gnt_o = 4'b0001;
        2'd1:    gnt_o = 4'b0010;
        2'd2:    gnt_o = 4'b0100;
        2'd3:    gnt_o = 4'b1000;
        default: gnt_o = 4'b0000;
      endcase
    end else begin
      gnt_o = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded grant-hold time and
// zero-bubble handoff between owners.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] hold_cnt
);

  localparam bit         LIMITED  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_MAX = LIMITED ? 8'(MAX_HOLD - 1) : 8'd255;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic       en_d;

  logic [3:0] owner_oh_s;
  logic [3:0] cand_s;
  logic       found_s;
  logic [1:0] win_s;
  logic       expire_s;
  logic       release_s;

  assign owner_oh_s = 4'b0001 << idx_q;
  // While granted, the current owner is excluded so a release hands straight to someone else.
  assign cand_s     = (state_q == ST_GRANT) ? (req & ~owner_oh_s) : req;
  assign expire_s   = LIMITED && (hold_q == HOLD_MAX) && ((req & ~owner_oh_s) != 4'b0000);
  assign release_s  = !req[idx_q] || expire_s;

  always_comb begin
    logic [1:0] pos;
    found_s = 1'b0;
    win_s   = 2'd0;
    pos     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      pos = ptr_q + 2'(k);
      if (!found_s && cand_s[pos]) begin
        found_s = 1'b1;
        win_s   = pos;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_GRANT;
          idx_d   = win_s;
          ptr_d   = win_s + 2'd1;
          hold_d  = 8'd0;
          en_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!release_s) begin
          en_d   = 1'b1;
          hold_d = (hold_q != HOLD_MAX) ? hold_q + 8'd1 : hold_q;
        end else if (found_s) begin
          en_d   = 1'b1;
          idx_d  = win_s;
          ptr_d  = win_s + 2'd1;
          hold_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
          hold_d  = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  rr_grant_decode u_decode (
    .idx_i (idx_d),
    .en_i  (en_d),
    .gnt_o (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign hold_cnt  = hold_q;

endmodule
